mem_access_scheduler: RTL and testbench

- Shares the single memory request port between NUM_REQ cores.
- Grants are round-robin. A granted core holds ownership for a burst of access_length beats.
- Per-core outstanding-transaction credits prevent any core from flooding memory with unanswered requests.
- Sits between the core request interfaces and the interconnect mux. It drives the one-hot grant that selects which core request goes to memory, and tracks the returning responses.

---
 rtl/mem_access_scheduler_pkg.sv | 13 +
 rtl/mem_access_scheduler_rr_pick.sv | 33 +++
 rtl/mem_access_scheduler.sv | 160 ++++++++++++++++
 tb/tb_mem_access_scheduler.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_scheduler_pkg.sv
// Shared types and sizing for the memory access scheduler.
// Core count and access_length width are the defaults used by the top and the picker.
package mem_access_scheduler_pkg;

  localparam int NUM_OF_CORES = 4;
  localparam int LEN_W        = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } sched_state_t;

endpackage

// File: rtl/mem_access_scheduler_rr_pick.sv
// Round-robin picker: first eligible core at or after rr_ptr, wrapping modulo N.
// Purely combinational so the rotation can be exercised on its own.
module mem_access_scheduler_rr_pick
  import mem_access_scheduler_pkg::*;
#(
  parameter int N  = NUM_OF_CORES,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] rr_ptr,
  output logic          found,
  output logic [IW-1:0] winner,
  output logic [N-1:0]  onehot
);

  logic [IW-1:0] idx_v;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    onehot = '0;
    idx_v  = '0;
    for (int k = 0; k < N; k++) begin
      idx_v = IW'((int'(rr_ptr) + k) % N);
      if (!found && eligible[idx_v]) begin
        found         = 1'b1;
        winner        = idx_v;
        onehot[idx_v] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_access_scheduler.sv
// Round-robin burst arbiter for the shared memory request port, with per-core
// outstanding-burst credits and a sticky error flag for unexpected responses.
//   state | meaning
//   IDLE  | no owner, grant=0, arbitrating every cycle
//   BURST | one core owns the port until its beat count expires or it drops req_vld
module mem_access_scheduler
  import mem_access_scheduler_pkg::*;
#(
  parameter int NUM_REQ = NUM_OF_CORES,
  parameter int LEN_W   = mem_access_scheduler_pkg::LEN_W,
  parameter int MAX_OUT = 4,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int OUT_W   = $clog2(MAX_OUT + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_vld,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  input  logic                     mem_ready,
  input  logic                     rsp_vld,
  input  logic [ID_W-1:0]          rsp_id,
  output logic [NUM_REQ-1:0]       grant,
  output logic [ID_W-1:0]          owner_id,
  output logic                     busy,
  output logic [NUM_REQ*OUT_W-1:0] outstanding,
  output logic                     credit_err
);

  sched_state_t        state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [ID_W-1:0]     owner_q, owner_d;
  logic                busy_q, busy_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [LEN_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [OUT_W-1:0]    out_q [NUM_REQ];
  logic [OUT_W-1:0]    out_d [NUM_REQ];
  logic                err_q, err_d;

  logic [NUM_REQ-1:0]  eligible;
  logic                pick_found;
  logic [ID_W-1:0]     pick_idx;
  logic [NUM_REQ-1:0]  pick_onehot;
  logic [LEN_W-1:0]    sel_len;
  logic                take;
  logic                id_ok;
  logic                rsp_zero;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_vld[i] && (out_q[i] < OUT_W'(MAX_OUT));
    end
  end

  mem_access_scheduler_rr_pick #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_rr_pick (
    .eligible (eligible),
    .rr_ptr   (rr_ptr_q),
    .found    (pick_found),
    .winner   (pick_idx),
    .onehot   (pick_onehot)
  );

  always_comb begin
    sel_len = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == ID_W'(i)) sel_len = req_len[i*LEN_W +: LEN_W];
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    take       = 1'b0;
    case (state_q)
      IDLE: take = pick_found;
      BURST: begin
        if (!req_vld[owner_q]) begin
          state_d    = IDLE;
          grant_d    = '0;
          beat_cnt_d = '0;
        end else if (mem_ready) begin
          if (beat_cnt_q == LEN_W'(1)) begin
            if (pick_found) begin
              take = 1'b1;
            end else begin
              state_d    = IDLE;
              grant_d    = '0;
              beat_cnt_d = '0;
            end
          end else begin
            beat_cnt_d = beat_cnt_q - 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A new owner is loaded identically from IDLE or straight off a last beat.
    if (take) begin
      state_d    = BURST;
      grant_d    = pick_onehot;
      owner_d    = pick_idx;
      rr_ptr_d   = (int'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + 1'b1;
      beat_cnt_d = (sel_len == '0) ? LEN_W'(1) : sel_len;
    end
    busy_d = (state_d == BURST);
  end

  always_comb begin
    err_d    = err_q;
    id_ok    = 32'(rsp_id) < 32'(NUM_REQ);
    rsp_zero = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      logic inc, dec;
      inc      = take && (pick_idx == ID_W'(i));
      dec      = rsp_vld && id_ok && (rsp_id == ID_W'(i)) && (out_q[i] != '0);
      rsp_zero = rsp_zero | ((rsp_id == ID_W'(i)) && (out_q[i] == '0));
      out_d[i] = out_q[i];
      if (inc && !dec)      out_d[i] = out_q[i] + 1'b1;
      else if (dec && !inc) out_d[i] = out_q[i] - 1'b1;
    end
    if (rsp_vld && (!id_ok || rsp_zero)) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      owner_q    <= '0;
      busy_q     <= 1'b0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) out_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      busy_q     <= busy_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
      for (int i = 0; i < NUM_REQ; i++) out_q[i] <= out_d[i];
    end
  end

  assign grant      = grant_q;
  assign owner_id   = owner_q;
  assign busy       = busy_q;
  assign credit_err = err_q;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_out
    assign outstanding[g*OUT_W +: OUT_W] = out_q[g];
  end

endmodule

// File: tb/tb_mem_access_scheduler.sv
// Scoreboard bench for mem_access_scheduler: stimulus queues the expected grant
// for each cycle, a negedge monitor pops and compares; counters checked inline.
module tb_mem_access_scheduler;

  localparam int NUM_REQ = 4;
  localparam int LEN_W   = 8;
  localparam int MAX_OUT = 4;
  localparam int ID_W    = 2;
  localparam int OUT_W   = 3;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_REQ-1:0]       req_vld;
  logic [NUM_REQ*LEN_W-1:0] req_len;
  logic                     mem_ready;
  logic                     rsp_vld;
  logic [ID_W-1:0]          rsp_id;
  logic [NUM_REQ-1:0]       grant;
  logic [ID_W-1:0]          owner_id;
  logic                     busy;
  logic [NUM_REQ*OUT_W-1:0] outstanding;
  logic                     credit_err;

  int n_tests = 0;
  int n_fail  = 0;
  logic [NUM_REQ-1:0] exp_q [$];

  mem_access_scheduler #(
    .NUM_REQ (NUM_REQ),
    .LEN_W   (LEN_W),
    .MAX_OUT (MAX_OUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_vld     (req_vld),
    .req_len     (req_len),
    .mem_ready   (mem_ready),
    .rsp_vld     (rsp_vld),
    .rsp_id      (rsp_id),
    .grant       (grant),
    .owner_id    (owner_id),
    .busy        (busy),
    .outstanding (outstanding),
    .credit_err  (credit_err)
  );

  always #5 clk = ~clk;

  function automatic int out_of(input int i);
    return int'(outstanding[i*OUT_W +: OUT_W]);
  endfunction

  function automatic int enc(input logic [NUM_REQ-1:0] oh);
    int r;
    r = 0;
    for (int i = 0; i < NUM_REQ; i++) if (oh[i]) r = i;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Cycle row: the grant expected in this cycle, then inputs driven for this cycle.
  task automatic step(input logic [3:0] vld, input logic mr, input logic rv,
                      input logic [1:0] rid, input logic [3:0] eg);
    @(posedge clk);
    #1;
    exp_q.push_back(eg);
    req_vld   = vld;
    mem_ready = mr;
    rsp_vld   = rv;
    rsp_id    = rid;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    req_vld = '0;
    rsp_vld = 1'b0;
    reset   = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin : monitor
    logic [NUM_REQ-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if (grant !== e || busy !== (|e)) begin
          n_fail++;
          $display("FAIL grant_trace: grant=%b busy=%b, expected grant=%b busy=%b",
                   grant, busy, e, |e);
        end
        if (e != '0) begin
          n_tests++;
          if (int'(owner_id) !== enc(e)) begin
            n_fail++;
            $display("FAIL owner_id: got %0d, expected %0d", owner_id, enc(e));
          end
        end
      end
    end
  end

  initial begin : stim
    reset     = 1'b1;
    req_vld   = '0;
    req_len   = '0;
    mem_ready = 1'b1;
    rsp_vld   = 1'b0;
    rsp_id    = '0;
    #1;
    chk("reset_grant", int'(grant), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_outstanding", int'(outstanding), 0);
    chk("reset_err", int'(credit_err), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // 1: lone core2, 3 beats
    req_len = {8'd1, 8'd3, 8'd1, 8'd1};
    step(4'b0100, 1, 0, 0, 4'b0000);
    step(4'b0100, 1, 0, 0, 4'b0100);
    step(4'b0100, 1, 0, 0, 4'b0100);
    step(4'b0000, 1, 0, 0, 4'b0100);
    step(4'b0000, 1, 0, 0, 4'b0000);
    chk("t1_out2", out_of(2), 1);

    // 2: all cores, 1 beat each, back-to-back rotation
    do_reset();
    req_len = {8'd1, 8'd1, 8'd1, 8'd1};
    step(4'b1111, 1, 0, 0, 4'b0000);
    step(4'b1111, 1, 0, 0, 4'b0001);
    step(4'b1111, 1, 0, 0, 4'b0010);
    step(4'b1111, 1, 0, 0, 4'b0100);
    step(4'b1111, 1, 0, 0, 4'b1000);
    step(4'b0000, 1, 0, 0, 4'b0001);
    step(4'b0000, 1, 0, 0, 4'b0000);
    chk("t2_out0", out_of(0), 2);
    chk("t2_out3", out_of(3), 1);

    // 3: core0, 4 beats with two stall cycles
    do_reset();
    req_len = {8'd1, 8'd1, 8'd1, 8'd4};
    step(4'b0001, 1, 0, 0, 4'b0000);
    step(4'b0001, 1, 0, 0, 4'b0001);
    step(4'b0001, 0, 0, 0, 4'b0001);
    step(4'b0001, 1, 0, 0, 4'b0001);
    step(4'b0001, 0, 0, 0, 4'b0001);
    step(4'b0001, 1, 0, 0, 4'b0001);
    step(4'b0000, 1, 0, 0, 4'b0001);
    step(4'b0000, 1, 0, 0, 4'b0000);
    chk("t3_out0", out_of(0), 1);

    // 4: core1 exhausts its credits, one response frees one more burst
    do_reset();
    req_len = {8'd1, 8'd1, 8'd1, 8'd1};
    step(4'b0010, 1, 0, 0, 4'b0000);
    step(4'b0010, 1, 0, 0, 4'b0010);
    step(4'b0010, 1, 0, 0, 4'b0010);
    step(4'b0010, 1, 0, 0, 4'b0010);
    step(4'b0010, 1, 0, 0, 4'b0010);
    step(4'b0010, 1, 0, 0, 4'b0000);
    step(4'b0010, 1, 1, 1, 4'b0000);
    chk("t4_out1_full", out_of(1), 4);
    step(4'b0010, 1, 0, 0, 4'b0000);
    chk("t4_out1_after_rsp", out_of(1), 3);
    step(4'b0000, 1, 0, 0, 4'b0010);
    step(4'b0000, 1, 0, 0, 4'b0000);
    chk("t4_out1_refilled", out_of(1), 4);

    // 5a: response to a core with nothing outstanding
    step(4'b0000, 1, 1, 3, 4'b0000);
    step(4'b0000, 1, 0, 0, 4'b0000);
    chk("t5_err_set", int'(credit_err), 1);
    chk("t5_out3_zero", out_of(3), 0);
    step(4'b0000, 1, 0, 0, 4'b0000);
    chk("t5_err_sticky", int'(credit_err), 1);
    chk("t5_out1_untouched", out_of(1), 4);

    // 5b: grant and response on core0 in the same cycle at count 2; len 0 acts as 1
    do_reset();
    chk("t5_err_cleared", int'(credit_err), 0);
    req_len = {8'd1, 8'd1, 8'd1, 8'd0};
    step(4'b0001, 1, 0, 0, 4'b0000);
    step(4'b0001, 1, 0, 0, 4'b0001);
    step(4'b0001, 1, 1, 0, 4'b0001);
    chk("t5_out0_before", out_of(0), 2);
    step(4'b0000, 1, 0, 0, 4'b0001);
    chk("t5_out0_same_cycle", out_of(0), 2);
    step(4'b0000, 1, 0, 0, 4'b0000);
    chk("t5_out0_final", out_of(0), 2);
    chk("t5_no_err", int'(credit_err), 0);

    // 6: reset in the middle of a 5-beat core1 burst
    do_reset();
    req_len = {8'd1, 8'd1, 8'd5, 8'd1};
    step(4'b0010, 1, 0, 0, 4'b0000);
    step(4'b0010, 1, 0, 0, 4'b0010);
    step(4'b0010, 1, 0, 0, 4'b0010);
    #6;
    reset = 1'b1;
    #1;
    chk("t6_grant_abort", int'(grant), 0);
    chk("t6_busy_abort", int'(busy), 0);
    chk("t6_out_abort", int'(outstanding), 0);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    req_vld = '0;
    step(4'b1001, 1, 0, 0, 4'b0000);
    step(4'b0000, 1, 0, 0, 4'b0001);
    step(4'b0000, 1, 0, 0, 4'b0000);
    chk("t6_out0", out_of(0), 1);
    chk("t6_out3", out_of(3), 0);

    @(posedge clk);
    @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
